// File: rtl/rancore_sched_pkg.sv
// rtl/rancore_sched_pkg.sv - shared types for the axon spike scheduler
//
// Purpose: FSM state encoding and the axon index width helper used by
//          axon_spike_scheduler and spike_pingpong_buf.
// Ports:   none (package).
package rancore_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ALIGN,
    SWEEP,
    FINISH
  } sched_state_e;

  localparam int DEFAULT_NUM_AXONS = 256;

  // Width of an axon index; kept at least 1 so a single-axon core still has a port.
  function automatic int axon_idx_w(input int num_axons);
    return (num_axons > 1) ? $clog2(num_axons) : 1;
  endfunction

endpackage

// File: rtl/spike_pingpong_buf.sv
// rtl/spike_pingpong_buf.sv - ping-pong spike bitmap pair
//
// Purpose: one bitmap collects spikes for the next tick while the other is
//          read and cleared by the scheduler; swap_i exchanges the roles.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears both maps, sel=0)
//   set_i, set_idx_i    OR a bit into the collect map
//   swap_i              exchange collect/process roles at this edge
//   rd_idx_i, rd_bit_o  combinational read of the process map
//   clr_i, clr_idx_i    clear a bit in the process map
module spike_pingpong_buf
  import rancore_sched_pkg::*;
#(
  parameter int NUM_AXONS = DEFAULT_NUM_AXONS,
  localparam int AW = axon_idx_w(NUM_AXONS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_i,
  input  logic [AW-1:0] set_idx_i,
  input  logic          swap_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic          rd_bit_o,
  input  logic          clr_i,
  input  logic [AW-1:0] clr_idx_i
);

  logic [NUM_AXONS-1:0] buf0_q, buf0_d;
  logic [NUM_AXONS-1:0] buf1_q, buf1_d;
  // sel_q=0: buf0 collects, buf1 is processed; sel_q=1: the reverse.
  logic                 sel_q;
  logic                 set_to_buf1;

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    // A spike in the swap cycle must land in the map that collects after the swap.
    set_to_buf1 = sel_q ^ swap_i;
    if (clr_i) begin
      if (sel_q) buf0_d[clr_idx_i] = 1'b0;
      else       buf1_d[clr_idx_i] = 1'b0;
    end
    if (set_i) begin
      if (set_to_buf1) buf1_d[set_idx_i] = 1'b1;
      else             buf0_d[set_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf0_q <= '0;
      buf1_q <= '0;
      sel_q  <= 1'b0;
    end else begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      sel_q  <= sel_q ^ swap_i;
    end
  end

  assign rd_bit_o = sel_q ? buf0_q[rd_idx_i] : buf1_q[rd_idx_i];

endmodule

// File: rtl/axon_spike_scheduler.sv
// rtl/axon_spike_scheduler.sv - per-tick axon sweep initiator
//
// Purpose: collects spikes into a ping-pong bitmap and, on each tick, presents
//          every spiking axon for one neuron sweep framed by two
//          synap_con_done pulses, then pulses tick_done.
// Optional: AXON_SCHED_STATS_EN adds spike_count (axons swept this tick).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   spike_in_valid, spike_in_axon  incoming spike for the next tick
//   tick                           start-of-tick strobe
//   synap_con_done                 sweep boundary pulse from the synapse engine
//   axon_number, axon_valid        axon currently being swept
//   busy                           tick in progress
//   tick_done                      one-cycle pulse at end of tick
//   tick_overrun                   sticky: tick arrived while busy
//   spike_count (optional)         sweeps completed in the current/last tick
module axon_spike_scheduler
  import rancore_sched_pkg::*;
#(
  parameter int NUM_AXONS   = DEFAULT_NUM_AXONS,
  parameter int NUM_NEURONS = 256,
  localparam int AW = axon_idx_w(NUM_AXONS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spike_in_valid,
  input  logic [AW-1:0] spike_in_axon,
  input  logic          tick,
  input  logic          synap_con_done,
`ifdef AXON_SCHED_STATS_EN
  output logic [AW:0]   spike_count,
`endif
  output logic [AW-1:0] axon_number,
  output logic          axon_valid,
  output logic          busy,
  output logic          tick_done,
  output logic          tick_overrun
);

  // Sweep length is defined by synap_con_done; NUM_NEURONS only documents it.
  if (NUM_NEURONS < 1) begin : g_num_neurons_invalid
  end

  localparam logic [AW-1:0] LAST_AXON = AW'(NUM_AXONS - 1);

  sched_state_e  state_q;
  logic [AW-1:0] scan_ptr_q;
  logic [AW-1:0] axon_number_q;
  logic          axon_valid_q;
  logic          busy_q;
  logic          tick_done_q;
  logic          tick_overrun_q;
`ifdef AXON_SCHED_STATS_EN
  logic [AW:0]   spike_count_q;
`endif

  logic swap;
  logic clr;
  logic rd_bit;

  assign swap = (state_q == IDLE) && tick;
  assign clr  = (state_q == SWEEP) && synap_con_done;

  spike_pingpong_buf #(
    .NUM_AXONS (NUM_AXONS)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .set_i     (spike_in_valid),
    .set_idx_i (spike_in_axon),
    .swap_i    (swap),
    .rd_idx_i  (scan_ptr_q),
    .rd_bit_o  (rd_bit),
    .clr_i     (clr),
    .clr_idx_i (axon_number_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      scan_ptr_q     <= '0;
      axon_number_q  <= '0;
      axon_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      tick_done_q    <= 1'b0;
      tick_overrun_q <= 1'b0;
`ifdef AXON_SCHED_STATS_EN
      spike_count_q  <= '0;
`endif
    end else begin
      tick_done_q <= 1'b0;
      if (tick && busy_q) tick_overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (tick) begin
            busy_q     <= 1'b1;
            scan_ptr_q <= '0;
            state_q    <= SCAN;
`ifdef AXON_SCHED_STATS_EN
            spike_count_q <= '0;
`endif
          end
        end

        SCAN: begin
          if (rd_bit) begin
            axon_number_q <= scan_ptr_q;
            state_q       <= ALIGN;
          end else if (scan_ptr_q == LAST_AXON) begin
            state_q <= FINISH;
          end else begin
            scan_ptr_q <= scan_ptr_q + AW'(1);
          end
        end

        // The first done pulse only frames the start; the sweep runs until the next one.
        ALIGN: begin
          if (synap_con_done) begin
            axon_valid_q <= 1'b1;
            state_q      <= SWEEP;
          end
        end

        SWEEP: begin
          if (synap_con_done) begin
            axon_valid_q <= 1'b0;
`ifdef AXON_SCHED_STATS_EN
            spike_count_q <= spike_count_q + (AW+1)'(1);
`endif
            if (scan_ptr_q == LAST_AXON) begin
              state_q <= FINISH;
            end else begin
              scan_ptr_q <= scan_ptr_q + AW'(1);
              state_q    <= SCAN;
            end
          end
        end

        FINISH: begin
          tick_done_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign axon_number  = axon_number_q;
  assign axon_valid   = axon_valid_q;
  assign busy         = busy_q;
  assign tick_done    = tick_done_q;
  assign tick_overrun = tick_overrun_q;
`ifdef AXON_SCHED_STATS_EN
  assign spike_count  = spike_count_q;
`endif

endmodule
